// File: rtl/button_event.sv
// button_event: turns debounced button levels into press / auto-repeat / release events.
//
// Each lane runs a small FSM (IDLE -> WAIT -> REPEAT) driven by edge detection on its
// level. Press and release pulses are registered and last one cycle. Every pulse also
// sets a per-lane pending bit. A single output register serialises pending events onto a
// valid/ready stream. The lowest lane is served first, and within a lane press comes
// before release.
//
// Ports:
//   clock         system clock
//   reset         asynchronous active-low reset
//   button        debounced, clock-synchronous button levels
//   press         one-cycle pulse per press or auto-repeat
//   release_pulse one-cycle pulse per release ("release" is a reserved word)
//   held          high while a lane is auto-repeating
//   evt_valid     event stream valid
//   evt_ready     event stream ready from the consumer
//   evt_code      lane index of the presented event
//   evt_type      0 = press/repeat, 1 = release
//   overflow      sticky flag: an event was dropped because its pending bit was still set
module button_event #(
    parameter int unsigned N_BUTTONS     = 5,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_BUTTONS-1:0] press,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] held,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [2:0]           evt_code,
    output logic                 evt_type,
    output logic                 overflow
);

    localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                       : REPEAT_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StRepeat} state_t;

    state_t                 state_q [N_BUTTONS];
    state_t                 state_d [N_BUTTONS];
    logic   [CNT_W-1:0]     cnt_q   [N_BUTTONS];
    logic   [CNT_W-1:0]     cnt_d   [N_BUTTONS];
    logic   [N_BUTTONS-1:0] prev_q;
    logic   [N_BUTTONS-1:0] rise, fall;
    logic   [N_BUTTONS-1:0] press_d, release_d;
    logic   [N_BUTTONS-1:0] pp_q, pp_d, pr_q, pr_d;
    logic   [N_BUTTONS-1:0] clr_pp, clr_pr;
    logic                   load, found, sel_type, overflow_d;
    logic   [2:0]           sel_code;

    assign rise = button & ~prev_q;
    assign fall = ~button & prev_q;

    // Lane FSMs: next state, counters, pulses and the held level.
    always_comb begin
        for (int i = 0; i < N_BUTTONS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            held[i]      = (state_q[i] == StRepeat);
            unique case (state_q[i])
                StIdle: begin
                    if (rise[i]) begin
                        state_d[i] = StWait;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end
                end
                StWait: begin
                    // A release always wins over a terminal count in the same cycle.
                    if (fall[i]) begin
                        state_d[i]   = StIdle;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else if (cnt_q[i] == HOLD_LAST) begin
                        state_d[i] = StRepeat;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                StRepeat: begin
                    if (fall[i]) begin
                        state_d[i]   = StIdle;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else if (cnt_q[i] == REPEAT_LAST) begin
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // Event selection and pending-bit bookkeeping.
    always_comb begin
        load     = ~evt_valid | evt_ready;
        found    = 1'b0;
        sel_code = '0;
        sel_type = 1'b0;
        clr_pp   = '0;
        clr_pr   = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (!found && (pp_q[i] || pr_q[i])) begin
                found    = 1'b1;
                sel_code = 3'(i);
                sel_type = ~pp_q[i];
                if (pp_q[i]) begin
                    clr_pp[i] = load;
                end else begin
                    clr_pr[i] = load;
                end
            end
        end
        // A pulse landing on a bit that is being consumed this cycle just re-arms it.
        pp_d       = (pp_q & ~clr_pp) | press_d;
        pr_d       = (pr_q & ~clr_pr) | release_d;
        overflow_d = overflow | (|(press_d & pp_q & ~clr_pp))
                              | (|(release_d & pr_q & ~clr_pr));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            prev_q        <= '0;
            press         <= '0;
            release_pulse <= '0;
            pp_q          <= '0;
            pr_q          <= '0;
            evt_valid     <= 1'b0;
            evt_code      <= '0;
            evt_type      <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            prev_q        <= button;
            press         <= press_d;
            release_pulse <= release_d;
            pp_q          <= pp_d;
            pr_q          <= pr_d;
            overflow      <= overflow_d;
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_code <= sel_code;
                    evt_type <= sel_type;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event with short hold/repeat times. A behavioural model predicts every
// output cycle by cycle from press age arithmetic and a pending-event set. Directed
// scenarios add literal expectations on pulse timing and on the transferred event order.
module tb_button_event;

    localparam int NB = 5;
    localparam int H  = 8;
    localparam int R  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] button = '0;
    logic          evt_ready = 1'b1;
    logic [NB-1:0] press, release_pulse, held;
    logic          evt_valid, evt_type, overflow;
    logic [2:0]    evt_code;

    button_event #(
        .N_BUTTONS    (NB),
        .HOLD_CYCLES  (H),
        .REPEAT_CYCLES(R)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button       (button),
        .press        (press),
        .release_pulse(release_pulse),
        .held         (held),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_type     (evt_type),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    int            cyc = 0;
    int            m_start [NB];
    logic [NB-1:0] m_prev, m_active, m_pp, m_pr;
    logic [NB-1:0] e_press, e_rel, e_held;
    logic [NB-1:0] np, nr, old_pp, old_pr, clr_p, clr_r;
    logic          e_valid, e_type, e_ovf;
    int            e_code;
    int            age;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_prev = '0; m_active = '0; m_pp = '0; m_pr = '0;
            e_press = '0; e_rel = '0; e_held = '0;
            e_valid = 1'b0; e_type = 1'b0; e_ovf = 1'b0; e_code = 0;
        end else begin
            cyc++;
            np = '0;
            nr = '0;
            for (int i = 0; i < NB; i++) begin
                if (m_active[i]) begin
                    age = cyc - m_start[i];
                    if (!button[i]) begin
                        nr[i] = 1'b1;
                        m_active[i] = 1'b0;
                    end else if (age >= H && ((age - H) % R) == 0) begin
                        np[i] = 1'b1;
                    end
                end else if (button[i] && !m_prev[i]) begin
                    m_active[i] = 1'b1;
                    m_start[i]  = cyc;
                    np[i]       = 1'b1;
                end
                e_held[i] = m_active[i] && ((cyc - m_start[i]) >= H);
            end
            m_prev = button;
            old_pp = m_pp;
            old_pr = m_pr;
            clr_p  = '0;
            clr_r  = '0;
            if (!e_valid || evt_ready) begin
                e_valid = 1'b0;
                for (int i = NB - 1; i >= 0; i--) begin
                    if (old_pp[i] || old_pr[i]) begin
                        e_valid = 1'b1;
                        e_code  = i;
                        e_type  = !old_pp[i];
                    end
                end
                if (e_valid) begin
                    if (!e_type) clr_p[e_code] = 1'b1;
                    else         clr_r[e_code] = 1'b1;
                end
            end
            m_pp = (old_pp & ~clr_p) | np;
            m_pr = (old_pr & ~clr_r) | nr;
            if (|(np & old_pp & ~clr_p) || |(nr & old_pr & ~clr_r)) e_ovf = 1'b1;
            e_press = np;
            e_rel   = nr;
        end
    end

    // ---------------- compare and observation ----------------
    int   press_cnt [NB] = '{default: 0};
    int   rel_cnt   [NB] = '{default: 0};
    int   held_cnt  [NB] = '{default: 0};
    int   rel_at    [NB] = '{default: 0};
    int   p0_q[$];
    int   held0_rise[$];
    int   log_ev[$];
    int   log_cyc[$];
    int   vcount = 0;
    logic held0_prev = 1'b0;

    always @(negedge clock) begin
        check("press", 32'(press), 32'(e_press));
        check("release", 32'(release_pulse), 32'(e_rel));
        check("held", 32'(held), 32'(e_held));
        check("evt_valid", 32'(evt_valid), 32'(e_valid));
        if (e_valid) begin
            check("evt_code", 32'(evt_code), 32'(e_code));
            check("evt_type", 32'(evt_type), 32'(e_type));
        end
        check("overflow", 32'(overflow), 32'(e_ovf));
        for (int i = 0; i < NB; i++) begin
            if (press[i]) press_cnt[i]++;
            if (release_pulse[i]) begin
                rel_cnt[i]++;
                rel_at[i] = cyc;
            end
            if (held[i]) held_cnt[i]++;
        end
        if (press[0]) p0_q.push_back(cyc);
        if (held[0] && !held0_prev) held0_rise.push_back(cyc);
        held0_prev = held[0];
        if (evt_valid) vcount++;
        if (evt_valid && evt_ready) begin
            log_ev.push_back(int'(evt_code) * 2 + int'(evt_type));
            log_cyc.push_back(cyc);
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    int t0, lb, pb, vb, rb, hb, pc;

    initial begin
        // Reset
        step(10);
        check("rst_press", 32'(press), 0);
        check("rst_release", 32'(release_pulse), 0);
        check("rst_held", 32'(held), 0);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_code", 32'(evt_code), 0);
        check("rst_type", 32'(evt_type), 0);
        check("rst_overflow", 32'(overflow), 0);
        reset = 1'b1;

        // Idle: no events
        vb = vcount;
        step(10);
        check("idle_valid_cycles", vcount - vb, 0);

        // Short press on lane 2
        lb = log_ev.size(); pc = press_cnt[2]; rb = rel_cnt[2]; hb = held_cnt[2];
        button[2] = 1'b1; t0 = cyc;
        step(3);
        button[2] = 1'b0;
        step(8);
        check("l2_press_count", press_cnt[2] - pc, 1);
        check("l2_release_count", rel_cnt[2] - rb, 1);
        check("l2_release_time", rel_at[2] - t0, 4);
        check("l2_held_never", held_cnt[2] - hb, 0);
        check("l2_events", log_ev.size() - lb, 2);
        check("l2_ev0", qget(log_ev, lb), 4);
        check("l2_ev1", qget(log_ev, lb + 1), 5);

        // Long hold on lane 0: auto-repeat
        lb = log_ev.size(); pb = p0_q.size(); hb = held0_rise.size();
        button[0] = 1'b1; t0 = cyc;
        step(20);
        button[0] = 1'b0;
        step(8);
        check("l0_press_count", p0_q.size() - pb, 4);
        check("l0_press_1", qget(p0_q, pb) - t0, 1);
        check("l0_press_2", qget(p0_q, pb + 1) - t0, 9);
        check("l0_press_3", qget(p0_q, pb + 2) - t0, 13);
        check("l0_press_4", qget(p0_q, pb + 3) - t0, 17);
        check("l0_held_from", qget(held0_rise, hb) - t0, 9);
        check("l0_release_time", rel_at[0] - t0, 21);
        check("l0_events", log_ev.size() - lb, 5);
        check("l0_no_overflow", 32'(overflow), 0);

        // Simultaneous rise on lanes 1 and 3
        lb = log_ev.size();
        button[1] = 1'b1; button[3] = 1'b1;
        step(3);
        button[1] = 1'b0; button[3] = 1'b0;
        step(8);
        check("l13_events", log_ev.size() - lb, 4);
        check("l13_ev0", qget(log_ev, lb), 2);
        check("l13_ev1", qget(log_ev, lb + 1), 6);
        check("l13_consecutive", qget(log_cyc, lb + 1) - qget(log_cyc, lb), 1);

        // Back-pressure on lane 4 leads to overflow
        evt_ready = 1'b0;
        lb = log_ev.size();
        button[4] = 1'b1;
        step(20);
        button[4] = 1'b0;
        step(4);
        check("bp_parked_valid", 32'(evt_valid), 1);
        check("bp_parked_code", 32'(evt_code), 4);
        check("bp_parked_type", 32'(evt_type), 0);
        check("bp_overflow", 32'(overflow), 1);
        evt_ready = 1'b1;
        step(6);
        check("bp_events", log_ev.size() - lb, 3);
        check("bp_ev0", qget(log_ev, lb), 8);
        check("bp_ev1", qget(log_ev, lb + 1), 8);
        check("bp_ev2", qget(log_ev, lb + 2), 9);
        check("bp_overflow_sticky", 32'(overflow), 1);

        // Reset in the middle of auto-repeat on lane 0
        button[0] = 1'b1;
        step(12);
        check("mid_held_before", 32'(held[0]), 1);
        reset = 1'b0;
        #1;
        check("mid_held_cleared", 32'(held), 0);
        check("mid_valid_cleared", 32'(evt_valid), 0);
        check("mid_overflow_cleared", 32'(overflow), 0);
        step(2);
        reset = 1'b1;
        lb = log_ev.size(); rb = rel_cnt[0];
        step(10);
        check("mid_no_release", rel_cnt[0] - rb, 0);
        check("mid_first_event", qget(log_ev, lb), 0);
        button[0] = 1'b0;
        step(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
